// File: rtl/lru_line_cache_if.sv
// Frontend lookup/response streams, backend fill streams, flush and statistics
// for lru_line_cache. The cache sits on the slave modport.
interface lru_line_cache_if #(
  parameter int unsigned TAG_WIDTH  = 48,
  parameter int unsigned LINE_WIDTH = 512,
  parameter int unsigned PORT_WIDTH = 512,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  fe_addr_tvalid;
  logic                  fe_addr_tready;
  logic [TAG_WIDTH-1:0]  fe_addr_tdata;
  logic                  fe_data_tvalid;
  logic                  fe_data_tready;
  logic [LINE_WIDTH-1:0] fe_data_tdata;
  logic                  be_addr_tvalid;
  logic                  be_addr_tready;
  logic [TAG_WIDTH-1:0]  be_addr_tdata;
  logic                  be_data_tvalid;
  logic                  be_data_tready;
  logic [PORT_WIDTH-1:0] be_data_tdata;
  logic                  flush;
  logic [CNT_WIDTH-1:0]  hit_count;
  logic [CNT_WIDTH-1:0]  miss_count;

  modport slave (
    input  fe_addr_tvalid, fe_addr_tdata, fe_data_tready,
    output fe_addr_tready, fe_data_tvalid, fe_data_tdata,
    output be_addr_tvalid, be_addr_tdata, be_data_tready,
    input  be_addr_tready, be_data_tvalid, be_data_tdata,
    input  flush,
    output hit_count, miss_count
  );

  modport master (
    output fe_addr_tvalid, fe_addr_tdata, fe_data_tready,
    input  fe_addr_tready, fe_data_tvalid, fe_data_tdata,
    input  be_addr_tvalid, be_addr_tdata, be_data_tready,
    output be_addr_tready, be_data_tvalid, be_data_tdata,
    output flush,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/lru_line_cache.sv
// Fully associative LRU line cache: single-cycle registered hits, multi-beat
// backend fill on miss, deferred flush while a fill is in flight.
module lru_line_cache #(
  parameter int unsigned TAG_WIDTH  = 48,
  parameter int unsigned LINE_WIDTH = 512,
  parameter int unsigned PORT_WIDTH = 512,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic             clk,
  input logic             rst,
  lru_line_cache_if.slave bus
);
  localparam int unsigned BEATS  = LINE_WIDTH / PORT_WIDTH;
  localparam int unsigned WAY_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, FILL, INSTALL} state_e;

  state_e                state_q;
  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [LINE_WIDTH-1:0] line_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [WAY_W-1:0]      rank_q [DEPTH];
  logic [WAY_W-1:0]      rank_d [DEPTH];
  logic [WAY_W-1:0]      victim_q;
  logic [TAG_WIDTH-1:0]  miss_tag_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  flush_pend_q;
  logic                  out_valid_q;
  logic [LINE_WIDTH-1:0] out_data_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q;
  logic [CNT_WIDTH-1:0]  miss_cnt_q;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_d;
  logic             victim_found;
  logic             out_free;
  logic             flush_any;
  logic             accept;
  logic             install;
  logic             promote;
  logic [WAY_W-1:0] promote_way;
  logic [WAY_W-1:0] promote_rank;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == bus.fe_addr_tdata)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
  end

  // Lowest-index invalid way wins over the LRU way.
  always_comb begin
    victim_d     = '0;
    victim_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rank_q[i] == WAY_W'(DEPTH - 1)) victim_d = WAY_W'(i);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !victim_found) begin
        victim_d     = WAY_W'(i);
        victim_found = 1'b1;
      end
    end
  end

  assign out_free  = !out_valid_q || bus.fe_data_tready;
  assign flush_any = flush_pend_q || bus.flush;
  assign accept    = bus.fe_addr_tvalid && bus.fe_addr_tready;
  assign install   = (state_q == INSTALL) && out_free;

  assign promote      = (accept && hit) || install;
  assign promote_way  = install ? victim_q : hit_way;
  assign promote_rank = rank_q[promote_way];

  // rank 0 is MRU; ways more recent than the promoted one age by one.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rank_d[i] = rank_q[i];
      if (promote) begin
        if (WAY_W'(i) == promote_way)    rank_d[i] = '0;
        else if (rank_q[i] < promote_rank) rank_d[i] = rank_q[i] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      beat_q       <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) rank_q[i] <= WAY_W'(i);
    end else begin
      rank_q <= rank_d;
      if (out_valid_q && bus.fe_data_tready) out_valid_q <= 1'b0;
      // A flush seen outside IDLE is held until the in-flight fill has been returned.
      if ((state_q == IDLE) && flush_any) begin
        valid_q      <= '0;
        flush_pend_q <= 1'b0;
      end else if (bus.flush) begin
        flush_pend_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              out_valid_q <= 1'b1;
              hit_cnt_q   <= hit_cnt_q + CNT_WIDTH'(1);
            end else begin
              miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
              state_q    <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.be_addr_tready) begin
            beat_q  <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (bus.be_data_tvalid) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(BEATS - 1)) state_q <= INSTALL;
          end
        end
        INSTALL: begin
          if (out_free) begin
            valid_q[victim_q] <= 1'b1;
            out_valid_q       <= 1'b1;
            state_q           <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept && hit) out_data_q <= line_q[hit_way];
      if (accept && !hit) begin
        miss_tag_q <= bus.fe_addr_tdata;
        victim_q   <= victim_d;
      end
      if ((state_q == FILL) && bus.be_data_tvalid) begin
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (beat_q == BEAT_W'(k)) line_q[victim_q][k*PORT_WIDTH +: PORT_WIDTH] <= bus.be_data_tdata;
        end
      end
      if (install) begin
        tag_q[victim_q] <= miss_tag_q;
        out_data_q      <= line_q[victim_q];
      end
    end
  end

  assign bus.fe_addr_tready = (state_q == IDLE) && out_free && !flush_any;
  assign bus.fe_data_tvalid = out_valid_q;
  assign bus.fe_data_tdata  = out_data_q;
  assign bus.be_addr_tvalid = (state_q == REQ);
  assign bus.be_addr_tdata  = miss_tag_q;
  assign bus.be_data_tready = (state_q == FILL);
  assign bus.hit_count      = hit_cnt_q;
  assign bus.miss_count     = miss_cnt_q;
endmodule

// File: tb/tb_lru_line_cache.sv
// Directed bench for lru_line_cache: DEPTH=8, two 8-bit beats per 16-bit line,
// with a behavioural backend that can stall the request and gap the beats.
module tb_lru_line_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lru_line_cache_if #(.TAG_WIDTH(16), .LINE_WIDTH(16), .PORT_WIDTH(8), .CNT_WIDTH(16)) bus ();

  lru_line_cache #(
    .TAG_WIDTH(16), .LINE_WIDTH(16), .PORT_WIDTH(8), .DEPTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  logic [15:0] last_req_tag = '0;
  int addr_stall = 0;
  bit gap_mode = 1'b0;
  int exp_hits = 0;
  int exp_misses = 0;

  typedef struct {
    logic [15:0] tag;
    bit          hit;
    bit          flush_first;
    logic [15:0] exp_line;
    int          exp_lat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fill_fn(input logic [15:0] tag);
    if (tag == 16'h1234) return 16'h0B0A;
    return {tag[7:0] ^ 8'h5A, tag[7:0]};
  endfunction

  function automatic logic [15:0] tg(input int i);
    return 16'(16'h0100 + i);
  endfunction

  task automatic add(input logic [15:0] tag, input bit hit, input bit fl);
    vec_t v;
    v.tag = tag; v.hit = hit; v.flush_first = fl;
    v.exp_line = fill_fn(tag);
    v.exp_lat = hit ? 1 : 5;
    vecs.push_back(v);
  endtask

  // Backend line store: reacts at negedges, bookkeeping of handshakes seen at the previous posedge.
  initial begin : backend
    int stall_cnt;
    int beat;
    bit addr_hs, data_hs;
    logic [15:0] hs_tag, held, cur_line;
    stall_cnt = 0; beat = 2; addr_hs = 0; data_hs = 0;
    hs_tag = '0; held = '0; cur_line = '0;
    bus.be_addr_tready = 1'b0;
    bus.be_data_tvalid = 1'b0;
    bus.be_data_tdata  = '0;
    forever begin
      @(negedge clk);
      if (addr_hs) begin
        req_cnt++;
        last_req_tag = hs_tag;
        cur_line = fill_fn(hs_tag);
        beat = 0;
      end
      if (data_hs) beat++;
      if (rst) begin
        bus.be_addr_tready = 1'b0;
        bus.be_data_tvalid = 1'b0;
        stall_cnt = 0;
      end else begin
        if (bus.be_addr_tvalid) begin
          if (stall_cnt == 0) held = bus.be_addr_tdata;
          else chk("be_addr_hold", bus.be_addr_tdata, held);
          bus.be_addr_tready = (stall_cnt >= addr_stall);
          if (!bus.be_addr_tready) stall_cnt++;
        end else begin
          bus.be_addr_tready = 1'b0;
          stall_cnt = 0;
        end
        bus.be_data_tvalid = bus.be_data_tready && (beat < 2) &&
                             (!gap_mode || ($urandom_range(0, 1) == 1));
        bus.be_data_tdata  = 8'(cur_line >> (8 * beat));
      end
      #1;
      addr_hs = !rst && bus.be_addr_tvalid && bus.be_addr_tready;
      hs_tag  = bus.be_addr_tdata;
      data_hs = !rst && bus.be_data_tvalid && bus.be_data_tready;
      if (rst) beat = 2;
    end
  end

  // Present one lookup, wait for acceptance, then for its response (fe_data_tready held by caller).
  task automatic lookup(input logic [15:0] tag, output logic [15:0] resp, output int lat);
    int n;
    resp = '0;
    lat = 0;
    @(posedge clk); #1;
    bus.fe_addr_tvalid = 1'b1;
    bus.fe_addr_tdata  = tag;
    n = 0;
    @(negedge clk);
    while (!bus.fe_addr_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("lookup_accepted", bus.fe_addr_tready, 1);
    if (!bus.fe_addr_tready) begin
      bus.fe_addr_tvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.fe_addr_tvalid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.fe_data_tvalid && lat < 300);
    chk("response_seen", bus.fe_data_tvalid, 1);
    resp = bus.fe_data_tdata;
  endtask

  task automatic flush_pulse();
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_fe_addr_tready"}, bus.fe_addr_tready, 1);
    chk({tagname, "_fe_data_tvalid"}, bus.fe_data_tvalid, 0);
    chk({tagname, "_be_addr_tvalid"}, bus.be_addr_tvalid, 0);
    chk({tagname, "_be_data_tready"}, bus.be_data_tready, 0);
    chk({tagname, "_hit_count"}, bus.hit_count, 0);
    chk({tagname, "_miss_count"}, bus.miss_count, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] resp;
    int lat, r0, n;

    bus.fe_addr_tvalid = 1'b0;
    bus.fe_addr_tdata  = '0;
    bus.fe_data_tready = 1'b1;
    bus.flush          = 1'b0;

    // LRU scenario 1: T8 evicts T0, then the re-missed T0 evicts T1, and so on down the order.
    for (int i = 0; i < 8; i++) add(tg(i), 1'b0, i == 0);
    add(tg(8), 0, 0); add(tg(0), 0, 0); add(tg(8), 1, 0); add(tg(7), 1, 0);
    add(tg(1), 0, 0); add(tg(3), 1, 0); add(tg(2), 0, 0); add(tg(4), 0, 0);
    // LRU scenario 2: touching T0 and T1 after the fill makes T2 the victim of T8.
    for (int i = 0; i < 8; i++) add(tg(i), 1'b0, i == 0);
    add(tg(0), 1, 0); add(tg(1), 1, 0); add(tg(8), 0, 0); add(tg(2), 0, 0);
    add(tg(0), 1, 0); add(tg(1), 1, 0); add(tg(3), 0, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Cold miss: one backend request, beats assembled low-first, BEATS+3 latency.
    r0 = req_cnt;
    lookup(16'h1234, resp, lat);
    exp_misses++;
    chk("cold_req_count", req_cnt - r0, 1);
    chk("cold_req_tag", last_req_tag, 16'h1234);
    chk("cold_resp", resp, 16'h0B0A);
    chk("cold_latency", lat, 5);
    chk("cold_miss_count", bus.miss_count, exp_misses);

    // Three back-to-back hits, one per cycle.
    r0 = req_cnt;
    @(posedge clk); #1;
    bus.fe_addr_tvalid = 1'b1;
    bus.fe_addr_tdata  = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_tready_%0d", k), bus.fe_addr_tready, 1);
      if (k > 0) begin
        chk($sformatf("b2b_tvalid_%0d", k), bus.fe_data_tvalid, 1);
        chk($sformatf("b2b_data_%0d", k), bus.fe_data_tdata, 16'h0B0A);
      end
      @(posedge clk); #1;
    end
    bus.fe_addr_tvalid = 1'b0;
    exp_hits += 3;
    @(negedge clk);
    chk("b2b_tvalid_last", bus.fe_data_tvalid, 1);
    chk("b2b_data_last", bus.fe_data_tdata, 16'h0B0A);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_drained", bus.fe_data_tvalid, 0);
    chk("b2b_hit_count", bus.hit_count, exp_hits);
    chk("b2b_no_backend", req_cnt - r0, 0);

    // Response backpressure: output held, lookups blocked, nothing lost or duplicated.
    @(posedge clk); #1;
    bus.fe_data_tready = 1'b0;
    bus.fe_addr_tvalid = 1'b1;
    bus.fe_addr_tdata  = 16'h1234;
    @(negedge clk);
    chk("bp_first_accept", bus.fe_addr_tready, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("bp_hold_valid_%0d", k), bus.fe_data_tvalid, 1);
      chk($sformatf("bp_hold_data_%0d", k), bus.fe_data_tdata, 16'h0B0A);
      chk($sformatf("bp_blocked_%0d", k), bus.fe_addr_tready, 0);
    end
    @(posedge clk); #1;
    bus.fe_data_tready = 1'b1;
    @(negedge clk);
    chk("bp_drain_accept", bus.fe_addr_tready, 1);
    @(posedge clk); #1;
    bus.fe_addr_tvalid = 1'b0;
    exp_hits += 2;
    @(negedge clk);
    chk("bp_second_valid", bus.fe_data_tvalid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_no_duplicate", bus.fe_data_tvalid, 0);
    chk("bp_hit_count", bus.hit_count, exp_hits);

    // Flush in IDLE gates a simultaneous lookup and invalidates the cached tag.
    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.fe_addr_tvalid = 1'b1;
    bus.fe_addr_tdata  = 16'h1234;
    @(negedge clk);
    chk("flush_idle_gated", bus.fe_addr_tready, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.fe_addr_tvalid = 1'b0;
    r0 = req_cnt;
    lookup(16'h1234, resp, lat);
    exp_misses++;
    chk("flush_idle_remiss", req_cnt - r0, 1);
    chk("flush_idle_resp", resp, 16'h0B0A);

    foreach (vecs[i]) begin
      if (vecs[i].flush_first) flush_pulse();
      r0 = req_cnt;
      lookup(vecs[i].tag, resp, lat);
      if (vecs[i].hit) exp_hits++;
      else exp_misses++;
      chk($sformatf("v%0d_backend_reqs", i), req_cnt - r0, vecs[i].hit ? 0 : 1);
      if (!vecs[i].hit) chk($sformatf("v%0d_req_tag", i), last_req_tag, vecs[i].tag);
      chk($sformatf("v%0d_resp", i), resp, vecs[i].exp_line);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
    end
    chk("table_hit_count", bus.hit_count, exp_hits);
    chk("table_miss_count", bus.miss_count, exp_misses);

    // Backend stalls the request four cycles, then delivers beats with random gaps.
    addr_stall = 4;
    gap_mode = 1'b1;
    r0 = req_cnt;
    lookup(16'h0777, resp, lat);
    exp_misses++;
    addr_stall = 0;
    gap_mode = 1'b0;
    chk("stall_req_count", req_cnt - r0, 1);
    chk("stall_req_tag", last_req_tag, 16'h0777);
    chk("stall_resp", resp, fill_fn(16'h0777));
    chk("stall_miss_count", bus.miss_count, exp_misses);

    // Flush during FILL: the fill is still returned, then the tag is gone.
    fork
      lookup(16'h0055, resp, lat);
      begin
        int m;
        m = 0;
        while (!bus.be_data_tready && m < 100) begin
          @(negedge clk);
          m++;
        end
        chk("flush_fill_reached", bus.be_data_tready, 1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
      end
    join
    exp_misses++;
    chk("flush_fill_resp", resp, fill_fn(16'h0055));
    r0 = req_cnt;
    lookup(16'h0055, resp, lat);
    exp_misses++;
    chk("flush_fill_remiss", req_cnt - r0, 1);
    chk("flush_fill_resp2", resp, fill_fn(16'h0055));
    chk("flush_fill_miss_count", bus.miss_count, exp_misses);
    chk("flush_fill_hit_count", bus.hit_count, exp_hits);

    // Reset in the middle of a fill.
    @(posedge clk); #1;
    bus.fe_addr_tvalid = 1'b1;
    bus.fe_addr_tdata  = 16'h0066;
    @(negedge clk);
    chk("rstfill_accept", bus.fe_addr_tready, 1);
    @(posedge clk); #1;
    bus.fe_addr_tvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.be_data_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rstfill_in_fill", bus.be_data_tready, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rstfill");
    exp_hits = 0;
    exp_misses = 0;
    r0 = req_cnt;
    lookup(16'h1234, resp, lat);
    exp_misses++;
    chk("post_rst_req", req_cnt - r0, 1);
    chk("post_rst_resp", resp, 16'h0B0A);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_miss_count", bus.miss_count, exp_misses);
    chk("post_rst_hit_count", bus.hit_count, exp_hits);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
